// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions: ALU opcodes and the ID/EX pipeline entry.
// Used by the ID/EX stage, its forwarding selector and the ALU.
package riscv_pkg;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    localparam logic [3:0] OP_ADD         = 4'b0000;
    localparam logic [3:0] OP_SUB         = 4'b0001;
    localparam logic [3:0] OP_MUL         = 4'b0010;
    localparam logic [3:0] OP_DIV         = 4'b0011;
    localparam logic [3:0] OP_SHIFT_LEFT  = 4'b0100;
    localparam logic [3:0] OP_SHIFT_RIGHT = 4'b0101;

    typedef struct packed {
        logic [3:0]       operation;
        logic [XLEN-1:0]  operand1;
        logic [XLEN-1:0]  operand2;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             regWrite;
    } pipe_entry_t;

    function automatic logic is_div_by_zero(input pipe_entry_t e);
        return (e.operation == OP_DIV) && (e.operand2 == '0);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand source selection for one register operand: EX bus, then MEM bus,
// then the supplied default value. Register x0 never forwards.
module fwd_select
    import riscv_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [XLEN-1:0]  baseData,
    input  logic             exFwdValid,
    input  logic             exFwdPending,
    input  logic [REG_W-1:0] exFwdRd,
    input  logic [XLEN-1:0]  exFwdData,
    input  logic             memFwdValid,
    input  logic [REG_W-1:0] memFwdRd,
    input  logic [XLEN-1:0]  memFwdData,
    output logic [XLEN-1:0]  selData
);

    logic w_exHit;
    logic w_memHit;

    assign w_exHit  = exFwdValid && !exFwdPending && (exFwdRd == rs) && (rs != '0);
    assign w_memHit = memFwdValid && (memFwdRd == rs) && (rs != '0);

    always_comb begin
        selData = baseData;
        if (w_exHit) begin
            selData = exFwdData;
        end else if (w_memHit) begin
            selData = memFwdData;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX single-entry pipeline register with operand forwarding and load-use stall.
// Forwarding is enabled by defining ID_EX_FORWARDING_EN; otherwise operands come from the register file.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [3:0]       inOperation,
    input  logic [XLEN-1:0]  inRs1Data,
    input  logic [XLEN-1:0]  inRs2Data,
    input  logic [XLEN-1:0]  inImm,
    input  logic [REG_W-1:0] inRs1,
    input  logic [REG_W-1:0] inRs2,
    input  logic [REG_W-1:0] inRd,
    input  logic             inAluSrc,
    input  logic             inRegWrite,
    input  logic             exFwdValid,
    input  logic [REG_W-1:0] exFwdRd,
    input  logic [XLEN-1:0]  exFwdData,
    input  logic             exFwdPending,
    input  logic             memFwdValid,
    input  logic [REG_W-1:0] memFwdRd,
    input  logic [XLEN-1:0]  memFwdData,
    output logic             outValid,
    input  logic             outReady,
    output logic [3:0]       operation,
    output logic [XLEN-1:0]  operand1,
    output logic [XLEN-1:0]  operand2,
    output logic [REG_W-1:0] outRd,
    output logic             outRegWrite,
    output logic             divZero,
    input  logic             flush
);

    pipe_entry_t      r_entry;
    logic             r_valid;

    pipe_entry_t      w_capture;
    logic             w_stall;
    logic             w_inFire;
    logic             w_loadUse;
    logic             w_exValid;
    logic             w_memValid;
    logic [REG_W-1:0] w_rs1Sel;
    logic [REG_W-1:0] w_rs2Sel;
    logic [XLEN-1:0]  w_rs1Base;
    logic [XLEN-1:0]  w_rs2Base;
    logic [XLEN-1:0]  w_op1Sel;
    logic [XLEN-1:0]  w_op2Sel;

`ifdef ID_EX_FORWARDING_EN
    assign w_loadUse  = exFwdValid && exFwdPending && (exFwdRd != '0) &&
                        ((exFwdRd == inRs1) || ((exFwdRd == inRs2) && !inAluSrc));
    assign w_exValid  = exFwdValid;
    assign w_memValid = memFwdValid;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = exFwdValid ^ memFwdValid;
    assign w_loadUse    = 1'b0;
    assign w_exValid    = 1'b0;
    assign w_memValid   = 1'b0;
`endif

    assign w_stall  = r_valid && !outReady;
    assign inReady  = (!r_valid || outReady) && !w_loadUse && !flush;
    assign w_inFire = inValid && inReady;

    // A stalled entry cannot capture, so the selectors are shared between capture and refresh.
    assign w_rs1Sel  = w_stall ? r_entry.rs1      : inRs1;
    assign w_rs1Base = w_stall ? r_entry.operand1 : inRs1Data;
    assign w_rs2Sel  = w_stall ? r_entry.rs2      : inRs2;
    assign w_rs2Base = w_stall ? r_entry.operand2 : inRs2Data;

    fwd_select u_fwd_rs1 (
        .rs           (w_rs1Sel),
        .baseData     (w_rs1Base),
        .exFwdValid   (w_exValid),
        .exFwdPending (exFwdPending),
        .exFwdRd      (exFwdRd),
        .exFwdData    (exFwdData),
        .memFwdValid  (w_memValid),
        .memFwdRd     (memFwdRd),
        .memFwdData   (memFwdData),
        .selData      (w_op1Sel)
    );

    fwd_select u_fwd_rs2 (
        .rs           (w_rs2Sel),
        .baseData     (w_rs2Base),
        .exFwdValid   (w_exValid),
        .exFwdPending (exFwdPending),
        .exFwdRd      (exFwdRd),
        .exFwdData    (exFwdData),
        .memFwdValid  (w_memValid),
        .memFwdRd     (memFwdRd),
        .memFwdData   (memFwdData),
        .selData      (w_op2Sel)
    );

    // Immediate operands are held with rs2 = x0 so a stall refresh can never overwrite them.
    always_comb begin
        w_capture           = '0;
        w_capture.operation = inOperation;
        w_capture.operand1  = w_op1Sel;
        w_capture.operand2  = inAluSrc ? inImm : w_op2Sel;
        w_capture.rd        = inRd;
        w_capture.rs1       = inRs1;
        w_capture.rs2       = inAluSrc ? '0 : inRs2;
        w_capture.regWrite  = inRegWrite;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_inFire) begin
            r_valid <= 1'b1;
            r_entry <= w_capture;
        end else if (w_stall) begin
            r_entry.operand1 <= w_op1Sel;
            r_entry.operand2 <= w_op2Sel;
        end else if (outReady) begin
            r_valid <= 1'b0;
        end
    end

    assign outValid    = r_valid;
    assign operation   = r_entry.operation;
    assign operand1    = r_entry.operand1;
    assign operand2    = r_entry.operand2;
    assign outRd       = r_entry.rd;
    assign outRegWrite = r_entry.regWrite;
    assign divZero     = r_valid && is_div_by_zero(r_entry);

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random traffic
// compared against a behavioural model of the stage.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [3:0]  inOperation;
    logic [63:0] inRs1Data, inRs2Data, inImm;
    logic [4:0]  inRs1, inRs2, inRd;
    logic        inAluSrc, inRegWrite;
    logic        exFwdValid, exFwdPending, memFwdValid;
    logic [4:0]  exFwdRd, memFwdRd;
    logic [63:0] exFwdData, memFwdData;
    logic        outValid, outReady;
    logic [3:0]  operation;
    logic [63:0] operand1, operand2;
    logic [4:0]  outRd;
    logic        outRegWrite, divZero, flush;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rstN(rstN),
        .inValid(inValid), .inReady(inReady), .inOperation(inOperation),
        .inRs1Data(inRs1Data), .inRs2Data(inRs2Data), .inImm(inImm),
        .inRs1(inRs1), .inRs2(inRs2), .inRd(inRd),
        .inAluSrc(inAluSrc), .inRegWrite(inRegWrite),
        .exFwdValid(exFwdValid), .exFwdRd(exFwdRd), .exFwdData(exFwdData),
        .exFwdPending(exFwdPending),
        .memFwdValid(memFwdValid), .memFwdRd(memFwdRd), .memFwdData(memFwdData),
        .outValid(outValid), .outReady(outReady), .operation(operation),
        .operand1(operand1), .operand2(operand2), .outRd(outRd),
        .outRegWrite(outRegWrite), .divZero(divZero), .flush(flush)
    );

    // Reference state: what the stage is expected to hold.
    bit          m_valid;
    logic [3:0]  m_op;
    logic [63:0] m_op1, m_op2;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    bit          m_rw, m_imm;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] fwd(input logic [4:0] rs, input logic [63:0] dflt);
        if (!FWD || rs == 5'd0) return dflt;
        if (exFwdValid && !exFwdPending && exFwdRd == rs) return exFwdData;
        if (memFwdValid && memFwdRd == rs) return memFwdData;
        return dflt;
    endfunction

    function automatic logic [63:0] rnd64();
        if ($urandom_range(0, 3) == 0) return 64'd0;
        return {$urandom, $urandom};
    endfunction

    task automatic idle();
        inValid = 0; inOperation = 4'd0; inRs1Data = 0; inRs2Data = 0; inImm = 0;
        inRs1 = 0; inRs2 = 0; inRd = 0; inAluSrc = 0; inRegWrite = 0;
        exFwdValid = 0; exFwdPending = 0; exFwdRd = 0; exFwdData = 0;
        memFwdValid = 0; memFwdRd = 0; memFwdData = 0;
        outReady = 1; flush = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".outValid"}, 64'(outValid), 64'(m_valid));
        check({tag, ".divZero"}, 64'(divZero), 64'(m_valid && m_op == 4'b0011 && m_op2 == 64'd0));
        if (m_valid) begin
            check({tag, ".operation"}, 64'(operation), 64'(m_op));
            check({tag, ".operand1"}, operand1, m_op1);
            check({tag, ".operand2"}, operand2, m_op2);
            check({tag, ".outRd"}, 64'(outRd), 64'(m_rd));
            check({tag, ".outRegWrite"}, 64'(outRegWrite), 64'(m_rw));
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle(input string tag);
        bit lu, rdy;
        #1;
        lu  = FWD && exFwdValid && exFwdPending && exFwdRd != 0 &&
              (exFwdRd == inRs1 || (exFwdRd == inRs2 && !inAluSrc));
        rdy = (!m_valid || outReady) && !lu && !flush;
        check({tag, ".inReady"}, 64'(inReady), 64'(rdy));
        if (flush) begin
            m_valid = 0;
        end else if (inValid && rdy) begin
            m_valid = 1;
            m_op    = inOperation;
            m_op1   = fwd(inRs1, inRs1Data);
            m_op2   = inAluSrc ? inImm : fwd(inRs2, inRs2Data);
            m_rd    = inRd;
            m_rw    = inRegWrite;
            m_rs1   = inRs1;
            m_rs2   = inRs2;
            m_imm   = inAluSrc;
        end else if (m_valid && !outReady) begin
            m_op1 = fwd(m_rs1, m_op1);
            if (!m_imm) m_op2 = fwd(m_rs2, m_op2);
        end else begin
            m_valid = 0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".outValid"}, 64'(outValid), 64'd0);
        check({tag, ".operation"}, 64'(operation), 64'd0);
        check({tag, ".operand1"}, operand1, 64'd0);
        check({tag, ".operand2"}, operand2, 64'd0);
        check({tag, ".outRd"}, 64'(outRd), 64'd0);
        check({tag, ".outRegWrite"}, 64'(outRegWrite), 64'd0);
        check({tag, ".divZero"}, 64'(divZero), 64'd0);
    endtask

    initial begin
        idle();
        m_valid = 0;
        rstN = 0;
        #1;
        check_all_zero("reset0");
        @(negedge clk);
        @(negedge clk);
        rstN = 1;

        // pass-through add
        idle();
        inValid = 1; inOperation = 4'b0000; inRs1 = 1; inRs2 = 2; inRd = 9; inRegWrite = 1;
        inRs1Data = 64'd5; inRs2Data = 64'd7;
        cycle("pass");
        check("pass.op1_const", operand1, 64'd5);
        check("pass.op2_const", operand2, 64'd7);

        // forwarding priority, then x0 never forwards
        idle();
        inValid = 1; inRs1 = 3; inRs1Data = 64'h11;
        exFwdValid = 1; exFwdRd = 3; exFwdData = 64'hAA;
        memFwdValid = 1; memFwdRd = 3; memFwdData = 64'hBB;
        cycle("prio");
        inRs1 = 0; exFwdRd = 0; memFwdRd = 0;
        cycle("prio_x0");

        // load-use stall then release
        idle();
        inValid = 1; inRs2 = 4; inRs2Data = 64'h99; inAluSrc = 0;
        exFwdValid = 1; exFwdPending = 1; exFwdRd = 4; exFwdData = 64'h77;
        cycle("ldu_stall");
        exFwdPending = 0; exFwdData = 64'h10;
        cycle("ldu_go");

        // stall refresh of a held operand
        idle();
        inValid = 1; inRs1 = 6; inRs1Data = 64'h1;
        cycle("hold_cap");
        idle();
        outReady = 0; memFwdValid = 1; memFwdRd = 6; memFwdData = 64'h55;
        cycle("refresh");

        // div-by-zero, then flush with a competing input
        idle();
        inValid = 1; inOperation = 4'b0011; inRs1Data = 64'd20; inRs2 = 5; inRs2Data = 0;
        cycle("div_cap");
        idle();
        outReady = 0;
        cycle("div_hold");
        inValid = 1; inOperation = 4'b0000; inRs1Data = 64'd3; flush = 1;
        cycle("flush");

        // asynchronous reset mid-cycle while holding a valid entry
        idle();
        inValid = 1; inOperation = 4'b0111; inRs1Data = 64'h123; inRd = 7; inRegWrite = 1;
        cycle("pre_rst");
        idle();
        outReady = 0;
        #2 rstN = 0;
        #1;
        check_all_zero("reset_mid");
        m_valid = 0;
        @(negedge clk);
        rstN = 1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            inValid      = ($urandom_range(0, 3) != 0);
            inOperation  = 4'($urandom_range(0, 7));
            inRs1Data    = rnd64();
            inRs2Data    = rnd64();
            inImm        = rnd64();
            inRs1        = 5'($urandom_range(0, 7));
            inRs2        = 5'($urandom_range(0, 7));
            inRd         = 5'($urandom_range(0, 31));
            inAluSrc     = ($urandom_range(0, 3) == 0);
            inRegWrite   = 1'($urandom);
            exFwdValid   = 1'($urandom);
            exFwdPending = ($urandom_range(0, 3) == 0);
            exFwdRd      = 5'($urandom_range(0, 7));
            exFwdData    = rnd64();
            memFwdValid  = 1'($urandom);
            memFwdRd     = 5'($urandom_range(0, 7));
            memFwdData   = rnd64();
            outReady     = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 15) == 0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
